uart_tx_buffered: RTL and testbench

UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

---
 rtl/uart_tx_buffered_if.sv | 9 +
 rtl/uart_tx_buffered.sv | 132 +++++++++++++
 tb/tb_uart_tx_buffered.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffered_if.sv
// Byte-stream handshake into the buffered UART transmitter.
interface uart_tx_buffered_if;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;

  modport master (output data_i, output valid_i, input ready_o);
  modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a small FIFO; one frame = start, 8 data bits LSB first, stop.
module uart_tx_buffered #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  uart_tx_buffered_if.slave  in_if,
  output logic               txd,
  output logic               busy,
  output logic [4:0]         fifo_count
);
  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [4:0]    DEPTH_C   = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            txd_q, txd_d;
  logic            busy_q, busy_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [4:0]      count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic            push, pop, baud_done;

  assign in_if.ready_o = (count_q < DEPTH_C);
  assign push          = in_if.valid_i && in_if.ready_o;
  assign pop           = (state_q == IDLE) && (count_q != 5'd0);
  assign baud_done     = (baud_q == BAUD_LAST);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + 5'd1;
      2'b01:   count_d = count_q - 5'd1;
      default: count_d = count_q;
    endcase
  end

  // txd/busy are registered from the current state, so the line lags the FSM by one cycle
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = 1'b1;
    busy_d  = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        txd_d = 1'b0;
        if (baud_done) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        txd_d = shift_q[0];
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage carries no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push) mem_q[wr_ptr_q] <= in_if.data_i;
  end

  assign txd        = txd_q;
  assign busy       = busy_q;
  assign fifo_count = count_q;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench: stimulus queues expected bytes, a line monitor decodes frames and compares.
module tb_uart_tx_buffered;
  localparam int DIV = 10;

  logic       clk;
  logic       rst;
  logic       txd;
  logic       busy;
  logic [4:0] fifo_count;

  uart_tx_buffered_if bus ();

  uart_tx_buffered #(.CLK_FREQ(1000), .BAUD_RATE(100), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_if      (bus),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] stim[$];
  logic       expect_b2b = 1'b0;
  logic       ready_low_seen;
  int         max_cnt;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  // Line monitor: samples txd/busy once per cycle on the falling edge
  logic mon_txd  [10*DIV];
  logic mon_busy [10*DIV];
  int   idle_run = 1000;
  logic pend     = 1'b0;

  initial begin
    logic       aborted, shape_ok;
    logic [7:0] rx;
    forever begin
      @(negedge clk);
      if (rst) begin
        idle_run = 1000;
        pend     = 1'b0;
      end else if (txd) begin
        idle_run++;
      end else begin
        if (pend) check("b2b_idle_gap", idle_run, 1);
        pend        = 1'b0;
        mon_txd[0]  = txd;
        mon_busy[0] = busy;
        aborted     = 1'b0;
        for (int k = 1; k < 10*DIV; k++) begin
          @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          mon_txd[k]  = txd;
          mon_busy[k] = busy;
        end
        if (aborted) begin
          idle_run = 1000;
        end else begin
          shape_ok = 1'b1;
          for (int k = 0; k < DIV; k++) if (mon_txd[k] !== 1'b0) shape_ok = 1'b0;
          for (int i = 0; i < 8; i++) begin
            rx[i] = mon_txd[DIV + DIV*i + DIV/2];
            for (int j = 0; j < DIV; j++)
              if (mon_txd[DIV + DIV*i + j] !== rx[i]) shape_ok = 1'b0;
          end
          for (int k = 9*DIV; k < 10*DIV; k++) if (mon_txd[k] !== 1'b1) shape_ok = 1'b0;
          for (int k = 0; k < 10*DIV; k++) if (mon_busy[k] !== 1'b1) shape_ok = 1'b0;
          check("frame_shape", int'(shape_ok), 1);
          if (exp_q.size() == 0) begin
            check("unexpected_frame", int'(rx), -1);
          end else begin
            check("frame_byte", int'(rx), int'(exp_q.pop_front()));
          end
          @(negedge clk);
          if (!rst) begin
            check("frame_end_idle", int'({txd, busy}), 2);
            idle_run = 1;
            pend     = expect_b2b && (exp_q.size() > 0);
          end
        end
      end
    end
  end

  // Holds valid_i high over the stim list; ready_o is stable between edges, so a
  // byte driven while ready_o=1 is taken at the next edge. Stalled cycles drive junk.
  task automatic stream();
    int i = 0;
    int guard = 0;
    int cnt_before;
    logic stalled;
    ready_low_seen = 1'b0;
    max_cnt = 0;
    @(negedge clk);
    while (i < stim.size() && guard < 3000) begin
      bus.valid_i = 1'b1;
      stalled     = !bus.ready_o;
      cnt_before  = int'(fifo_count);
      if (stalled) begin
        ready_low_seen = 1'b1;
        bus.data_i     = 8'hEE;
      end else begin
        bus.data_i = stim[i];
        exp_q.push_back(stim[i]);
        i++;
      end
      @(negedge clk);
      guard++;
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      if (stalled) check("stall_count_held", int'(fifo_count > 5'(cnt_before)), 0);
    end
    bus.valid_i = 1'b0;
    check("stream_all_accepted", i, stim.size());
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!(exp_q.size() == 0 && !busy && fifo_count == 5'd0) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", int'(guard >= 3000), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int   guard;
    logic low_seen;
    rst         = 1'b1;
    bus.valid_i = 1'b0;
    bus.data_i  = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_txd", int'(txd), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_ready", int'(bus.ready_o), 1);
    check("reset_count", int'(fifo_count), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single 0xA5 from idle, with push-to-start latency
    bus.data_i  = 8'hA5;
    bus.valid_i = 1'b1;
    exp_q.push_back(8'hA5);
    @(negedge clk);
    bus.valid_i = 1'b0;
    check("lat_count_after_push", int'(fifo_count), 1);
    check("lat_txd_n", int'(txd), 1);
    check("lat_busy_n", int'(busy), 0);
    @(negedge clk);
    check("lat_count_after_pop", int'(fifo_count), 0);
    check("lat_txd_n1", int'(txd), 1);
    @(negedge clk);
    check("lat_txd_n2", int'(txd), 0);
    check("lat_busy_n2", int'(busy), 1);
    wait_idle();

    // Four consecutive pushes: never full, frames separated by one idle cycle
    expect_b2b = 1'b1;
    stim = '{8'h01, 8'h02, 8'h03, 8'h04};
    stream();
    check("b2b_ready_never_low", int'(ready_low_seen), 0);
    wait_idle();
    expect_b2b = 1'b0;

    // Six pushes with valid held: FIFO fills, later bytes wait for a free slot
    stim = '{8'h3C, 8'hC3, 8'h5A, 8'h81, 8'h7E, 8'hE7};
    stream();
    check("full_max_count", max_cnt, 4);
    check("full_ready_low", int'(ready_low_seen), 1);
    wait_idle();

    // Reset 35 cycles into a 0xFF frame with two bytes still queued
    stim = '{8'hFF, 8'h11, 8'h22};
    stream();
    guard = 0;
    while (txd && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("rst_frame_started", int'(txd), 0);
    repeat (35) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_txd_async", int'(txd), 1);
    check("rst_busy_async", int'(busy), 0);
    check("rst_count_async", int'(fifo_count), 0);
    check("rst_ready_async", int'(bus.ready_o), 1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    low_seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!txd || busy) low_seen = 1'b1;
    end
    check("post_rst_quiet", int'(low_seen), 0);
    check("post_rst_count", int'(fifo_count), 0);

    // 0x00: line low for start plus eight data bits, then stop
    stim = '{8'h00};
    stream();
    wait_idle();

    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
